// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl -- sequencing controller for a CIC decimator.
//
// Accepts upstream samples and enables the integrator chain on each accept.
// It counts accepts modulo the decimation ratio R. Every R-th accept raises a
// decimation tick. The tick travels through an N_STAGES-deep delay line and
// then pulses comb_en. The first N_STAGES comb pulses after start-up only
// prime the comb chain. Later pulses raise out_valid, which is held until the
// downstream accepts it. A result that lands while out_valid is stalled is
// dropped, and the sticky ovf_flag is set.
//
// Optional feature: define CIC_CTRL_BYPASS_EN to add the `bypass` input.
// With bypass=1, R is treated as 1, warm-up is skipped and comb_en fires in
// the same cycle as int_en.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ctrl_en    run request
//   cfg_load   strobe: capture dec_ratio (IDLE only)
//   dec_ratio  decimation ratio R (0 is stored as 1)
//   bypass     (CIC_CTRL_BYPASS_EN only) pass-through mode
//   in_valid   upstream sample valid
//   in_ready   controller accepts the sample
//   int_en     integrator enable (= accept)
//   comb_en    comb chain enable
//   out_valid  decimated output valid
//   out_ready  downstream accepts the output
//   ovf_flag   sticky output overrun
//   cfg_err    one-cycle pulse on a rejected cfg_load
//   busy       state is not IDLE
module cic_decim_ctrl #(
   parameter int unsigned CNT_WIDTH = 8,
   parameter int unsigned N_STAGES  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ctrl_en,
   input  logic                 cfg_load,
   input  logic [CNT_WIDTH-1:0] dec_ratio,
`ifdef CIC_CTRL_BYPASS_EN
   input  logic                 bypass,
`endif
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 int_en,
   output logic                 comb_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 ovf_flag,
   output logic                 cfg_err,
   output logic                 busy
);

   localparam int unsigned          WARM_W    = $clog2(N_STAGES + 1);
   localparam logic [WARM_W-1:0]    WARM_DONE = WARM_W'(N_STAGES);
   localparam logic [WARM_W-1:0]    WARM_LAST = WARM_W'(N_STAGES - 1);
   localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StWarmup, StRun, StFlush} state_e;

   state_e               state_q;
   logic [CNT_WIDTH-1:0] ratio_q;
   logic [CNT_WIDTH-1:0] phase_q;
   logic [N_STAGES-1:0]  dline_q;
   logic [N_STAGES-1:0]  dline_d;
   // Comb pulses seen since leaving IDLE, saturating at N_STAGES.
   logic [WARM_W-1:0]    warm_q;
   logic                 out_valid_q;
   logic                 ovf_q;
   logic                 cfg_err_q;

   logic bypass_w;
   logic stall;
   logic accept;
   logic phase_last;
   logic dec_tick;
   logic produce;

`ifdef CIC_CTRL_BYPASS_EN
   assign bypass_w = bypass;
`else
   assign bypass_w = 1'b0;
`endif

   always_comb begin
      stall      = out_valid_q & ~out_ready;
      in_ready   = ((state_q == StWarmup) || (state_q == StRun)) && !stall;
      accept     = in_valid & in_ready;
      int_en     = accept;
      phase_last = (phase_q == ratio_q - ONE);
      dec_tick   = accept & (bypass_w | phase_last);
      // In bypass mode the tick skips the delay line and fires comb_en at once.
      comb_en    = dline_q[N_STAGES-1] | (dec_tick & bypass_w);
      // Only pulses after the chain has been primed carry a real result.
      produce    = comb_en & (warm_q == WARM_DONE);
      dline_d    = dline_q << 1;
      dline_d[0] = dec_tick & ~bypass_w;
   end

   assign out_valid = out_valid_q;
   assign ovf_flag  = ovf_q;
   assign cfg_err   = cfg_err_q;
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ratio_q     <= ONE;
         phase_q     <= '0;
         dline_q     <= '0;
         warm_q      <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         cfg_err_q <= cfg_load && (state_q != StIdle);
         dline_q   <= dline_d;

         if (accept) begin
            phase_q <= (bypass_w || phase_last) ? '0 : phase_q + ONE;
         end

         if (comb_en && (warm_q != WARM_DONE)) begin
            warm_q <= warm_q + 1'b1;
         end

         // A new result keeps out_valid high; if the previous one is still
         // stalled, the new one is lost and the overrun is recorded.
         if (produce) begin
            out_valid_q <= 1'b1;
            if (stall) begin
               ovf_q <= 1'b1;
            end
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            StIdle: begin
               if (cfg_load) begin
                  ratio_q <= (dec_ratio == '0) ? ONE : dec_ratio;
                  ovf_q   <= 1'b0;
               end
               if (ctrl_en) begin
                  if (bypass_w) begin
                     state_q <= StRun;
                     warm_q  <= WARM_DONE;
                  end else begin
                     state_q <= StWarmup;
                  end
               end
            end
            StWarmup: begin
               if (!ctrl_en) begin
                  state_q <= StFlush;
               end else if (comb_en && (warm_q == WARM_LAST)) begin
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (!ctrl_en) begin
                  state_q <= StFlush;
               end
            end
            StFlush: begin
               if ((dline_q == '0) && !out_valid_q) begin
                  state_q <= StIdle;
                  phase_q <= '0;
                  warm_q  <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl (default build, bypass feature off).
// A reference model tracks pending decimation ticks as a queue of due cycles
// and the run mode as a simple phase. All outputs are compared every cycle.
`timescale 1ns/1ps
module tb_cic_decim_ctrl;
   localparam int unsigned CW = 8;
   localparam int unsigned NS = 3;
   localparam int M_IDLE = 0, M_WARM = 1, M_RUN = 2, M_FLUSH = 3;

   logic          clk = 1'b0;
   logic          rst, ctrl_en, cfg_load, in_valid, out_ready;
   logic [CW-1:0] dec_ratio;
   logic          in_ready, int_en, comb_en, out_valid, ovf_flag, cfg_err, busy;

   int n_cmp = 0;
   int n_bad = 0;

   cic_decim_ctrl #(.CNT_WIDTH(CW), .N_STAGES(NS)) dut (
      .clk       (clk),
      .rst       (rst),
      .ctrl_en   (ctrl_en),
      .cfg_load  (cfg_load),
      .dec_ratio (dec_ratio),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .int_en    (int_en),
      .comb_en   (comb_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ovf_flag  (ovf_flag),
      .cfg_err   (cfg_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference model state.
   int   m_state, m_ratio, m_phase, m_combs, cyc;
   int   m_due[$];
   bit   m_ov, m_ovf, m_err;
   // Bit order: {in_ready, int_en, comb_en, out_valid, ovf_flag, cfg_err, busy}
   logic [6:0] exp_vec, obs_vec;

   function automatic void model_reset();
      m_state = M_IDLE;
      m_ratio = 1;
      m_phase = 0;
      m_combs = 0;
      m_due.delete();
      m_ov  = 0;
      m_ovf = 0;
      m_err = 0;
   endfunction

   // One clock: sample DUT and model at the falling edge, advance the model
   // over the rising edge, return 1 ns after it so inputs can be changed.
   task automatic step();
      bit e_rdy, e_int, e_comb, produce, flush_done;
      int n_after;
      @(negedge clk);
      e_rdy   = (m_state == M_WARM || m_state == M_RUN) && !(m_ov && !out_ready);
      e_int   = in_valid && e_rdy;
      e_comb  = (m_due.size() > 0) && (m_due[0] == cyc);
      exp_vec = {e_rdy, e_int, e_comb, m_ov, m_ovf, m_err, m_state != M_IDLE};
      obs_vec = {in_ready, int_en, comb_en, out_valid, ovf_flag, cfg_err, busy};
      if (rst) begin
         model_reset();
      end else begin
         flush_done = (m_due.size() == 0) && !m_ov;
         n_after = m_combs + (e_comb ? 1 : 0);
         m_err = cfg_load && (m_state != M_IDLE);
         if (e_comb) void'(m_due.pop_front());
         if (e_int) begin
            m_phase++;
            if (m_phase >= m_ratio) begin
               m_phase = 0;
               m_due.push_back(cyc + NS);
            end
         end
         produce = e_comb && (n_after > NS);
         if (produce) begin
            if (m_ov && !out_ready) m_ovf = 1;
            m_ov = 1;
         end else if (m_ov && out_ready) begin
            m_ov = 0;
         end
         case (m_state)
            M_IDLE: begin
               if (cfg_load) begin
                  m_ratio = (dec_ratio == 0) ? 1 : int'(dec_ratio);
                  m_ovf   = 0;
               end
               if (ctrl_en) begin
                  m_state = M_WARM;
                  n_after = 0;
               end
            end
            M_WARM: begin
               if (!ctrl_en) m_state = M_FLUSH;
               else if (n_after >= NS) m_state = M_RUN;
            end
            M_RUN: if (!ctrl_en) m_state = M_FLUSH;
            default: begin
               if (flush_done) begin
                  m_state = M_IDLE;
                  m_phase = 0;
                  n_after = 0;
               end
            end
         endcase
         m_combs = n_after;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int k;
      ctrl_en = 0; in_valid = 0; cfg_load = 0; out_ready = 1;
      for (k = 0; k < 60 && !(busy === 1'b0 && m_state == M_IDLE); k++) begin
         step();
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL drain cyc=%0d outputs=%b expected=%b", cyc, obs_vec, exp_vec);
         end
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_timeout busy=%b expected=0 after %0d cycles", busy, k);
      end
   endtask

   task automatic test_reset();
      rst = 1; ctrl_en = 1'($urandom); cfg_load = 1'($urandom); in_valid = 1'($urandom);
      out_ready = 1'($urandom); dec_ratio = CW'($urandom);
      step();   // outputs unknown before the first reset edge
      step();
      n_cmp++;
      if (obs_vec !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_outputs got=%b expected=0000000", obs_vec);
      end
      rst = 0; ctrl_en = 0; cfg_load = 0; in_valid = 0; out_ready = 0;
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
         n_bad++;
         $display("FAIL reset_idle outputs=%b expected=%b", obs_vec, exp_vec);
      end
      n_cmp++;
      if (dut.ratio_q !== CW'(1)) begin
         n_bad++;
         $display("FAIL reset_ratio got=%0d expected=1", dut.ratio_q);
      end
   endtask

   task automatic test_r4();
      int n_acc = 0, t_acc4 = -1, t_ov1 = -1;
      int t_comb[$];
      cfg_load = 1; dec_ratio = 4; out_ready = 1;
      step();
      cfg_load = 0; ctrl_en = 1; in_valid = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL r4_lockstep cyc=%0d outputs=%b expected=%b", cyc, obs_vec, exp_vec);
         end
         if (obs_vec[5] === 1'b1) begin
            n_acc++;
            if (n_acc == 4) t_acc4 = i;
         end
         if (obs_vec[4] === 1'b1) t_comb.push_back(i);
         if (obs_vec[3] === 1'b1 && t_ov1 < 0) t_ov1 = i;
      end
      n_cmp++;
      if (t_comb.size() < 6) begin
         n_bad++;
         $display("FAIL r4_comb_count got=%0d expected>=6", t_comb.size());
      end else begin
         n_cmp++;
         if (t_comb[0] != t_acc4 + 3) begin
            n_bad++;
            $display("FAIL r4_first_comb at=%0d expected=%0d", t_comb[0], t_acc4 + 3);
         end
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (t_comb[k+1] - t_comb[k] != 4) begin
               n_bad++;
               $display("FAIL r4_comb_spacing k=%0d got=%0d expected=4", k,
                        t_comb[k+1] - t_comb[k]);
            end
         end
         n_cmp++;
         if (t_ov1 != t_comb[3] + 1) begin
            n_bad++;
            $display("FAIL r4_first_out_valid at=%0d expected=%0d", t_ov1, t_comb[3] + 1);
         end
      end
   endtask

   // Runs straight after test_r4, still in RUN with R=4.
   task automatic test_cfg_in_run();
      int n_err = 0;
      cfg_load = 1; dec_ratio = 7;
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
         n_bad++;
         $display("FAIL cfgrun_lockstep outputs=%b expected=%b", obs_vec, exp_vec);
      end
      cfg_load = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL cfgrun_lockstep cyc=%0d outputs=%b expected=%b", cyc, obs_vec, exp_vec);
         end
         if (obs_vec[1] === 1'b1) n_err++;
         if (i == 0) begin
            n_cmp++;
            if (obs_vec[1] !== 1'b1) begin
               n_bad++;
               $display("FAIL cfgrun_err_pulse got=%b expected=1", obs_vec[1]);
            end
         end
      end
      n_cmp++;
      if (n_err != 1) begin
         n_bad++;
         $display("FAIL cfgrun_err_count got=%0d expected=1", n_err);
      end
      n_cmp++;
      if (dut.ratio_q !== CW'(4)) begin
         n_bad++;
         $display("FAIL cfgrun_ratio got=%0d expected=4", dut.ratio_q);
      end
      drain();
   endtask

   task automatic test_flush();
      int n_comb = 0, n_ov = 0, k;
      cfg_load = 1; dec_ratio = 2; out_ready = 1;
      step();
      cfg_load = 0; ctrl_en = 1; in_valid = 1;
      for (int i = 0; i < 20; i++) step();
      for (k = 0; k < 10 && m_due.size() != 2; k++) step();
      ctrl_en = 0; in_valid = 0;
      for (k = 0; k < 30 && !(busy === 1'b0 && k > 0); k++) begin
         step();
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL flush_lockstep cyc=%0d outputs=%b expected=%b", cyc, obs_vec, exp_vec);
         end
         if (obs_vec[4] === 1'b1) n_comb++;
         if (obs_vec[3] === 1'b1) n_ov++;
      end
      n_cmp++;
      if (n_comb != 2) begin
         n_bad++;
         $display("FAIL flush_comb_count got=%0d expected=2", n_comb);
      end
      n_cmp++;
      if (n_ov != 2) begin
         n_bad++;
         $display("FAIL flush_out_valid_count got=%0d expected=2", n_ov);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_busy got=%b expected=0", busy);
      end
      n_cmp++;
      if (dut.phase_q !== '0) begin
         n_bad++;
         $display("FAIL flush_phase got=%0d expected=0", dut.phase_q);
      end
   endtask

   task automatic test_r1_backpressure();
      int t_ov1 = -1;
      logic [6:0] prev;
      cfg_load = 1; dec_ratio = 1; out_ready = 0;
      step();
      cfg_load = 0; ctrl_en = 1; in_valid = 1;
      prev = '0;
      for (int i = 0; i < 20; i++) begin
         step();
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL r1bp_lockstep cyc=%0d outputs=%b expected=%b", cyc, obs_vec, exp_vec);
         end
         if (t_ov1 >= 0 && i == t_ov1 + 1) begin
            n_cmp++;
            if (obs_vec[6] !== 1'b0) begin
               n_bad++;
               $display("FAIL r1bp_in_ready got=%b expected=0", obs_vec[6]);
            end
         end
         if (obs_vec[3] === 1'b1 && t_ov1 < 0) t_ov1 = i;
         prev = obs_vec;
      end
      n_cmp++;
      if (prev[2] !== 1'b1) begin
         n_bad++;
         $display("FAIL r1bp_ovf got=%b expected=1", prev[2]);
      end
      drain();
      n_cmp++;
      if (ovf_flag !== 1'b1) begin
         n_bad++;
         $display("FAIL r1bp_ovf_sticky got=%b expected=1", ovf_flag);
      end
   endtask

   task automatic test_r0();
      int n_acc = 0, n_comb = 0;
      cfg_load = 1; dec_ratio = 0;
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
         n_bad++;
         $display("FAIL r0_lockstep outputs=%b expected=%b", obs_vec, exp_vec);
      end
      n_cmp++;
      if (dut.ratio_q !== CW'(1)) begin
         n_bad++;
         $display("FAIL r0_ratio got=%0d expected=1", dut.ratio_q);
      end
      n_cmp++;
      if (ovf_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL r0_ovf_clear got=%b expected=0", ovf_flag);
      end
      cfg_load = 0; ctrl_en = 1;
      for (int i = 0; i < 40; i++) begin
         in_valid  = ($urandom_range(99) < 70);
         out_ready = ($urandom_range(99) < 70);
         if (i == 39) begin ctrl_en = 0; in_valid = 0; end
         step();
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL r0_lockstep cyc=%0d outputs=%b expected=%b", cyc, obs_vec, exp_vec);
         end
         if (obs_vec[5] === 1'b1) n_acc++;
         if (obs_vec[4] === 1'b1) n_comb++;
      end
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (obs_vec[4] === 1'b1) n_comb++;
      end
      n_cmp++;
      if (n_comb != n_acc) begin
         n_bad++;
         $display("FAIL r0_every_accept_ticks combs=%0d expected=%0d", n_comb, n_acc);
      end
      drain();
   endtask

   task automatic test_random();
      int len;
      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(3) != 0) begin
            cfg_load = 1; dec_ratio = CW'($urandom_range(5));
            step();
            cfg_load = 0;
         end
         ctrl_en = 1;
         len = $urandom_range(80, 30);
         for (int i = 0; i < len; i++) begin
            in_valid  = ($urandom_range(99) < 75);
            out_ready = ($urandom_range(99) < 60);
            cfg_load  = ($urandom_range(99) < 5);
            dec_ratio = CW'($urandom_range(9));
            step();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
               n_bad++;
               $display("FAIL random_lockstep r=%0d cyc=%0d outputs=%b expected=%b",
                        r, cyc, obs_vec, exp_vec);
            end
         end
         drain();
      end
   endtask

   task automatic test_rst_mid_run();
      cfg_load = 1; dec_ratio = 1; out_ready = 1;
      step();
      cfg_load = 0; ctrl_en = 1; in_valid = 1;
      for (int i = 0; i < 15; i++) step();
      rst = 1; cfg_load = 1; dec_ratio = 5;
      step();
      rst = 0; cfg_load = 0; ctrl_en = 0; in_valid = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++;
         if (obs_vec !== 7'b0) begin
            n_bad++;
            $display("FAIL rst_mid_run i=%0d outputs=%b expected=0000000", i, obs_vec);
         end
      end
      n_cmp++;
      if (dut.ratio_q !== CW'(1)) begin
         n_bad++;
         $display("FAIL rst_mid_run_ratio got=%0d expected=1", dut.ratio_q);
      end
   endtask

   initial begin
      model_reset();
      cyc = 0;
      test_reset();
      test_r4();
      test_cfg_in_run();
      test_flush();
      test_r1_backpressure();
      test_r0();
      test_random();
      test_rst_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cic_decim_ctrl.md
CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, the width of the decimation ratio and phase counter.
REQ-002 SHALL have parameter N_STAGES, default 3, the number of integrator and comb stages (1..8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ctrl_en, input, 1 bit: run request.
REQ-006 SHALL have port cfg_load, input, 1 bit: capture-strobe for dec_ratio.
REQ-007 SHALL have port dec_ratio, input, CNT_WIDTH bits: decimation ratio R.
REQ-008 SHALL have port in_valid, input, 1 bit: upstream sample valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the controller accepts the sample.
REQ-010 SHALL have port int_en, output, 1 bit: enable for the integrator chain.
REQ-011 SHALL have port comb_en, output, 1 bit: enable for the comb chain.
REQ-012 SHALL have port out_valid, output, 1 bit: decimated output valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the output.
REQ-014 SHALL have port ovf_flag, output, 1 bit: sticky output-overrun flag.
REQ-015 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when cfg_load is rejected.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 SHALL implement the states IDLE, WARMUP, RUN and FLUSH.
REQ-018 SHALL make these transitions: IDLE->WARMUP when ctrl_en=1; WARMUP->RUN after N_STAGES comb_en pulses; WARMUP/RUN->FLUSH when ctrl_en=0; FLUSH->IDLE when the tick delay line is empty and out_valid=0.
REQ-019 SHALL capture dec_ratio into ratio_reg on cfg_load only in IDLE; a value of 0 SHALL be stored as 1.
REQ-020 SHALL ignore cfg_load outside IDLE and pulse cfg_err for one cycle instead.
REQ-021 SHALL drive in_ready = (state is WARMUP or RUN) AND NOT (out_valid AND NOT out_ready).
REQ-022 SHALL define accept = in_valid AND in_ready, and SHALL drive int_en = accept combinationally, in the same cycle.
REQ-023 SHALL count accepts in a phase counter from 0 to ratio_reg-1; on an accept at ratio_reg-1 the counter SHALL wrap to 0 and raise dec_tick.
REQ-024 SHALL delay dec_tick by exactly N_STAGES cycles through a shift register and then assert comb_en for one cycle.
REQ-025 SHALL set out_valid one cycle after each comb_en in RUN; comb_en pulses that occur in WARMUP SHALL NOT produce out_valid.
REQ-026 SHALL clear out_valid on out_valid AND out_ready, unless a new comb_en lands in the same cycle, in which case out_valid SHALL stay 1.
REQ-027 SHALL, when comb_en lands while out_valid=1 and out_ready=0, keep out_valid=1, drop the new result and set ovf_flag.
REQ-028 SHALL clear ovf_flag only on rst or on an accepted cfg_load.
REQ-029 SHALL, in FLUSH, hold in_ready=0 while ticks already in flight still produce comb_en and out_valid.
REQ-030 SHALL clear the phase counter on entry to IDLE.
REQ-031 SHALL, when ratio_reg=1, make every accept a dec_tick.

Reset
REQ-032 SHALL, on rst, set state=IDLE, ratio_reg=1, phase=0 and the delay line to 0.
REQ-033 SHALL, on rst, drive in_ready, int_en, comb_en, out_valid, ovf_flag, cfg_err and busy to 0.
REQ-034 SHALL let rst take priority over all inputs, including in the middle of WARMUP, RUN or FLUSH; any ticks in flight SHALL be discarded.

Configuration
REQ-035 SHALL add an input port bypass (1 bit) when macro CIC_CTRL_BYPASS_EN is defined.
REQ-036 SHALL, with the macro defined and bypass=1, treat R as 1, skip WARMUP (IDLE->RUN) and assert comb_en in the same cycle as int_en.
REQ-037 SHALL, without the macro, omit the bypass port and behave as if bypass=0.

Verification
REQ-038 SHALL verify: rst; cfg_load with R=4; ctrl_en=1; in_valid held high; out_ready=1 -> comb_en every 4th accept, 3 cycles after the tick; the first 3 comb_en give no out_valid; out_valid from the 4th comb_en onward.
REQ-039 SHALL verify: cfg_load while in RUN -> cfg_err pulses once and ratio_reg is unchanged.
REQ-040 SHALL verify: R=1 with out_ready=0 held -> in_ready drops the cycle after the first out_valid, and ovf_flag sets when an in-flight tick arrives.
REQ-041 SHALL verify: dec_ratio=0 loaded -> behaviour identical to R=1.
REQ-042 SHALL verify: ctrl_en dropped with 2 ticks in flight -> 2 further comb_en, then busy=0 and phase=0.
REQ-043 SHALL verify: rst asserted mid-RUN -> all outputs 0 on the next cycle and no comb_en afterwards.
